// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, receiver FSM states, parity helper.
// Latency: none (declarations only).
// Backpressure: not applicable.
package uart_pkg;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_EVEN = 1;
   localparam int PARITY_ODD  = 2;

   // Widest supported data word; narrower words are zero-extended into it
   localparam int MAX_DATA_BITS = 9;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_DATA      = 3'd2,
      ST_PARITY    = 3'd3,
      ST_STOP      = 3'd4,
      ST_WAIT_IDLE = 3'd5
   } rx_state_t;

   // XOR of all data bits; zero-extension of a narrower word leaves it unchanged
   function automatic logic parity_of(input logic [MAX_DATA_BITS-1:0] data);
      return ^data;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; head entry is presented combinationally.
// Latency: push visible at o_head_dat/o_count the cycle after i_push.
// Backpressure: push while full without a pop is dropped (caller flags it); pop while empty is ignored.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_push_dat,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_head_dat,
   output logic                     o_vld,
   output logic                     o_full,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_do_pop;
   logic             w_do_push;

   assign o_vld      = (r_count != '0);
   assign o_full     = (r_count == (AW+1)'(DEPTH));
   assign o_count    = r_count;
   // Empty FIFO presents zero so the output is defined straight out of reset
   assign o_head_dat = o_vld ? r_mem[r_rd_ptr] : '0;

   // A pop frees a slot in the same cycle, so push+pop on a full FIFO both succeed
   assign w_do_pop  = i_pop && o_vld;
   assign w_do_push = i_push && (!o_full || w_do_pop);

   // Storage array; contents need no reset because o_vld gates the head
   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= i_push_dat;
      end
   end

   // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/uart_rx_fifo.sv
// Parametrised UART receiver with sticky error flags feeding a show-ahead receive FIFO.
// Latency: last stop-bit midpoint on rx to rd_valid/count update is 3 clk (2 sync + 1).
// Backpressure: none toward the line; a frame arriving while the FIFO is full is dropped and err_overrun set.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int TICKS_PER_BIT = 2,
   parameter int DATA_BITS     = 8,
   parameter int PARITY        = 0,
   parameter int STOP_BITS     = 1,
   parameter int FIFO_DEPTH    = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          rx,
   input  logic                          rd_en,
   output logic [DATA_BITS-1:0]          rd_data,
   output logic                          rd_valid,
   output logic [$clog2(FIFO_DEPTH):0]   count,
   input  logic                          clr_err,
   output logic                          err_frame,
   output logic                          err_parity,
   output logic                          err_overrun
);

   localparam int TW = $clog2(TICKS_PER_BIT);
   localparam int BW = $clog2(DATA_BITS);
   localparam logic [TW-1:0] TICK_H     = TW'((TICKS_PER_BIT - 1) / 2);
   localparam logic [TW-1:0] TICK_LAST  = TW'(TICKS_PER_BIT - 1);
   localparam logic [BW-1:0] LAST_DATA  = BW'(DATA_BITS - 1);
   localparam logic [BW-1:0] LAST_STOP  = BW'(STOP_BITS - 1);
   localparam logic          PAR_INV    = (PARITY == PARITY_ODD);
   localparam logic          HAS_PARITY = (PARITY != PARITY_NONE);

   logic                 r_rx_meta;
   logic                 r_rx_sync;
   rx_state_t            r_state;
   rx_state_t            w_state_nxt;
   logic [TW-1:0]        r_tick;
   logic [TW-1:0]        w_tick_nxt;
   logic [BW-1:0]        r_bit_cnt;
   logic [BW-1:0]        w_bit_cnt_nxt;
   logic [DATA_BITS-1:0] r_shift;
   logic [DATA_BITS-1:0] w_shift_nxt;
   logic                 r_par_bad;
   logic                 w_par_bad_nxt;
   logic                 w_sample;
   logic                 w_bit_end;
   logic                 w_push;
   logic                 w_set_frame;
   logic                 w_set_parity;
   logic                 w_set_overrun;
   logic                 w_fifo_full;

   // Two-flop synchroniser; idles high so reset never looks like a start bit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rx_meta <= 1'b1;
         r_rx_sync <= 1'b1;
      end else begin
         r_rx_meta <= rx;
         r_rx_sync <= r_rx_meta;
      end
   end

   assign w_sample  = (r_tick == TICK_H);
   assign w_bit_end = (r_tick == TICK_LAST);

   // Receiver state, bit timer, bit counter and shift register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_tick    <= '0;
         r_bit_cnt <= '0;
         r_shift   <= '0;
         r_par_bad <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_tick    <= w_tick_nxt;
         r_bit_cnt <= w_bit_cnt_nxt;
         r_shift   <= w_shift_nxt;
         r_par_bad <= w_par_bad_nxt;
      end
   end

   // Next-state: timer runs on bit boundaries, every decision is taken at the midpoint tick
   always_comb begin
      w_state_nxt   = r_state;
      w_tick_nxt    = w_bit_end ? '0 : r_tick + TW'(1);
      w_bit_cnt_nxt = r_bit_cnt;
      w_shift_nxt   = r_shift;
      w_par_bad_nxt = r_par_bad;
      w_push        = 1'b0;
      w_set_frame   = 1'b0;
      w_set_parity  = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            w_tick_nxt    = '0;
            w_bit_cnt_nxt = '0;
            w_par_bad_nxt = 1'b0;
            if (!r_rx_sync) begin
               w_state_nxt = ST_START;
            end
         end
         ST_START: begin
            if (w_sample && r_rx_sync) begin
               w_state_nxt = ST_IDLE;
            end else if (w_bit_end) begin
               w_state_nxt = ST_DATA;
            end
         end
         ST_DATA: begin
            if (w_sample) begin
               w_shift_nxt = {r_rx_sync, r_shift[DATA_BITS-1:1]};
            end
            if (w_bit_end) begin
               if (r_bit_cnt == LAST_DATA) begin
                  w_bit_cnt_nxt = '0;
                  w_state_nxt   = HAS_PARITY ? ST_PARITY : ST_STOP;
               end else begin
                  w_bit_cnt_nxt = r_bit_cnt + BW'(1);
               end
            end
         end
         ST_PARITY: begin
            if (w_sample) begin
               w_par_bad_nxt = r_rx_sync != (parity_of(MAX_DATA_BITS'(r_shift)) ^ PAR_INV);
            end
            if (w_bit_end) begin
               w_state_nxt = ST_STOP;
            end
         end
         ST_STOP: begin
            if (w_sample) begin
               if (!r_rx_sync) begin
                  w_set_frame = 1'b1;
                  w_state_nxt = ST_WAIT_IDLE;
               end else if (r_bit_cnt == LAST_STOP) begin
                  w_set_parity = r_par_bad;
                  w_push       = !r_par_bad;
                  w_state_nxt  = ST_IDLE;
               end
            end else if (w_bit_end) begin
               w_bit_cnt_nxt = r_bit_cnt + BW'(1);
            end
         end
         ST_WAIT_IDLE: begin
            // A held-low line (break) must not be decoded as a stream of frames
            w_tick_nxt = '0;
            if (r_rx_sync) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // A full FIFO still accepts the push when the core pops in the same cycle
   assign w_set_overrun = w_push && w_fifo_full && !rd_en;

   // Sticky error flags; a new event wins over a simultaneous clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_frame   <= 1'b0;
         err_parity  <= 1'b0;
         err_overrun <= 1'b0;
      end else begin
         err_frame   <= (err_frame   && !clr_err) || w_set_frame;
         err_parity  <= (err_parity  && !clr_err) || w_set_parity;
         err_overrun <= (err_overrun && !clr_err) || w_set_overrun;
      end
   end

   sync_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_push     (w_push),
      .i_push_dat (r_shift),
      .i_pop      (rd_en),
      .o_head_dat (rd_data),
      .o_vld      (rd_valid),
      .o_full     (w_fifo_full),
      .o_count    (count)
   );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Two receivers: instance 0 is 8N1 at 2 clk/bit, instance 1 is 8O2 at 8 clk/bit.
// The model predicts each frame's outcome from its bit list and the edge where it lands.
// Both instances are compared against the model on every falling edge.
module tb_uart_rx_fifo;

   localparam int DB    = 8;
   localparam int DEPTH = 4;
   localparam int K_PUSH   = 0;
   localparam int K_FRAME  = 1;
   localparam int K_PARITY = 2;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx      [2];
   logic       rd_en   [2];
   logic       clr_err [2];
   logic [7:0] rd_data [2];
   logic       rd_valid[2];
   logic [2:0] count   [2];
   logic       err_frame  [2];
   logic       err_parity [2];
   logic       err_overrun[2];

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   uart_rx_fifo #(.TICKS_PER_BIT(2), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
      .clk(clk), .rst_n(rst_n), .rx(rx[0]), .rd_en(rd_en[0]), .rd_data(rd_data[0]),
      .rd_valid(rd_valid[0]), .count(count[0]), .clr_err(clr_err[0]),
      .err_frame(err_frame[0]), .err_parity(err_parity[0]), .err_overrun(err_overrun[0]));

   uart_rx_fifo #(.TICKS_PER_BIT(8), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_b (
      .clk(clk), .rst_n(rst_n), .rx(rx[1]), .rd_en(rd_en[1]), .rd_data(rd_data[1]),
      .rd_valid(rd_valid[1]), .count(count[1]), .clr_err(clr_err[1]),
      .err_frame(err_frame[1]), .err_parity(err_parity[1]), .err_overrun(err_overrun[1]));

   function automatic int tpb(input int i);
      return (i == 0) ? 2 : 8;
   endfunction
   function automatic int par(input int i);
      return (i == 0) ? 0 : 2;
   endfunction
   function automatic int stops(input int i);
      return (i == 0) ? 1 : 2;
   endfunction

   // ---------------- behavioural model ----------------
   typedef struct {
      int         inst;
      int         edge_n;
      int         kind;
      logic [7:0] data;
   } ev_t;

   ev_t        evq[$];
   int         cyc = 0;
   logic [7:0] mq  [2][DEPTH];
   int         mcnt[2];
   bit         mfe [2];
   bit         mpe [2];
   bit         mov [2];

   // Apply pops, clears and frame outcomes that take effect on this rising edge
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            mcnt[i] = 0; mfe[i] = 0; mpe[i] = 0; mov[i] = 0;
         end
         evq.delete();
      end else begin
         cyc++;
         for (int i = 0; i < 2; i++) begin
            if (rd_en[i] && mcnt[i] > 0) begin
               for (int k = 0; k < DEPTH - 1; k++) mq[i][k] = mq[i][k+1];
               mcnt[i]--;
            end
            if (clr_err[i]) begin
               mfe[i] = 0; mpe[i] = 0; mov[i] = 0;
            end
         end
         for (int k = evq.size() - 1; k >= 0; k--) begin
            if (evq[k].edge_n == cyc) begin
               case (evq[k].kind)
                  K_PUSH: begin
                     if (mcnt[evq[k].inst] < DEPTH) begin
                        mq[evq[k].inst][mcnt[evq[k].inst]] = evq[k].data;
                        mcnt[evq[k].inst]++;
                     end else begin
                        mov[evq[k].inst] = 1;
                     end
                  end
                  K_FRAME:  mfe[evq[k].inst] = 1;
                  default:  mpe[evq[k].inst] = 1;
               endcase
               evq.delete(k);
            end
         end
      end
   end

   // Every-cycle comparison of all outputs against the model
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         logic [14:0] act, exp;
         act = {rd_valid[i], count[i], err_frame[i], err_parity[i], err_overrun[i],
                (mcnt[i] > 0) ? rd_data[i] : 8'h00};
         exp = {mcnt[i] > 0, 3'(mcnt[i]), mfe[i], mpe[i], mov[i],
                (mcnt[i] > 0) ? mq[i][0] : 8'h00};
         n_checks++;
         if (act !== exp) begin
            n_errors++;
            $display("FAIL cycle_cmp inst%0d cyc%0d {vld,cnt,fe,pe,ov,data}: got %h expected %h",
                     i, cyc, act, exp);
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drive one frame starting at the current falling edge and schedule its outcome.
   // Bit b is sampled on sync'd rx at raw cycle e0+1+b*T+H, taking effect on edge e0+b*T+H+4.
   task automatic send(input int i, input logic [7:0] d, input bit par_ok,
                       input bit [1:0] stop_v, input int gap);
      int   t, h, p, s, nb, e0, ob, kind;
      logic bits[16];
      t  = tpb(i);
      h  = (t - 1) / 2;
      p  = (par(i) != 0) ? 1 : 0;
      s  = stops(i);
      nb = 1 + DB + p + s;
      bits[0] = 1'b0;
      for (int k = 0; k < DB; k++) bits[1+k] = d[k];
      if (p == 1) bits[1+DB] = (^d) ^ (par(i) == 2) ^ !par_ok;
      for (int j = 0; j < s; j++) bits[1+DB+p+j] = stop_v[j];
      e0 = cyc;
      ob = -1;
      kind = K_PUSH;
      for (int j = 0; j < s; j++) begin
         if (!stop_v[j] && ob < 0) begin
            ob = 1 + DB + p + j;
            kind = K_FRAME;
         end
      end
      if (ob < 0) begin
         ob = nb - 1;
         kind = (p == 1 && !par_ok) ? K_PARITY : K_PUSH;
      end
      evq.push_back('{i, e0 + ob * t + h + 4, kind, d});
      for (int b = 0; b < nb; b++) begin
         rx[i] = bits[b];
         repeat (t) @(negedge clk);
      end
      rx[i] = 1'b1;
      repeat (gap * t) @(negedge clk);
   endtask

   task automatic pop(input int i);
      rd_en[i] = 1'b1;
      @(negedge clk);
      rd_en[i] = 1'b0;
      @(negedge clk);
   endtask

   task automatic clear(input int i);
      clr_err[i] = 1'b1;
      @(negedge clk);
      clr_err[i] = 1'b0;
      @(negedge clk);
   endtask

   // Random frames (good / bad parity / bad stop) with random pops and clears alongside
   task automatic run_random(input int i, input int n);
      bit         done;
      logic [7:0] d;
      int         sel, gap;
      bit         pok;
      bit [1:0]   sv;
      done = 0;
      fork
         begin
            for (int f = 0; f < n; f++) begin
               d   = 8'($urandom);
               sel = $urandom_range(0, 9);
               pok = 1;
               sv  = 2'b11;
               if (sel == 0 && par(i) != 0) pok = 0;
               else if (sel == 1) sv = (stops(i) == 2) ? 2'($urandom_range(0, 2)) : 2'b10;
               gap = $urandom_range(0, 2);
               if (!sv[stops(i)-1] && gap == 0) gap = 1;
               send(i, d, pok, sv, gap);
            end
            repeat (12) @(negedge clk);
            done = 1;
         end
         begin
            while (!done) begin
               rd_en[i]   = ($urandom_range(0, 3) == 0);
               clr_err[i] = ($urandom_range(0, 15) == 0);
               @(negedge clk);
            end
            rd_en[i]   = 1'b0;
            clr_err[i] = 1'b0;
         end
      join
   endtask

   initial begin
      rx      = '{1'b1, 1'b1};
      rd_en   = '{1'b0, 1'b0};
      clr_err = '{1'b0, 1'b0};
      repeat (3) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         check("reset_valid", 32'(rd_valid[i]), 0);
         check("reset_count", 32'(count[i]), 0);
         check("reset_data", 32'(rd_data[i]), 0);
         check("reset_flags", 32'({err_frame[i], err_parity[i], err_overrun[i]}), 0);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // 8N1 single byte
      send(0, 8'h55, 1, 2'b11, 1);
      repeat (2) @(negedge clk);
      check("t1_valid", 32'(rd_valid[0]), 1);
      check("t1_data", 32'(rd_data[0]), 32'h55);
      check("t1_count", 32'(count[0]), 1);
      check("t1_model", 32'(mq[0][0]), 32'h55);
      pop(0);
      check("t1_pop_count", 32'(count[0]), 0);

      // Five back-to-back frames into a 4-deep FIFO
      for (int k = 1; k <= 5; k++) send(0, 8'(k), 1, 2'b11, 0);
      repeat (6) @(negedge clk);
      check("t2_count", 32'(count[0]), 4);
      check("t2_overrun", 32'(err_overrun[0]), 1);
      for (int k = 1; k <= 4; k++) begin
         check("t2_pop_data", 32'(rd_data[0]), 32'(k));
         pop(0);
      end
      check("t2_empty", 32'(rd_valid[0]), 0);
      clear(0);
      check("t2_clr", 32'(err_overrun[0]), 0);

      // Full FIFO, push and pop land on the same edge
      for (int k = 0; k < 4; k++) send(0, 8'h10 + 8'(k), 1, 2'b11, 0);
      fork
         send(0, 8'h20, 1, 2'b11, 2);
         begin
            repeat (21) @(negedge clk);
            rd_en[0] = 1'b1;
            @(negedge clk);
            rd_en[0] = 1'b0;
         end
      join
      check("full_pp_count", 32'(count[0]), 4);
      check("full_pp_overrun", 32'(err_overrun[0]), 0);
      check("full_pp_head", 32'(rd_data[0]), 32'h11);
      for (int k = 0; k < 4; k++) pop(0);

      // Bad stop bit, long break, then a good frame
      send(0, 8'h3C, 1, 2'b00, 0);
      rx[0] = 1'b0;
      repeat (40) @(negedge clk);
      rx[0] = 1'b1;
      repeat (4) @(negedge clk);
      send(0, 8'h7E, 1, 2'b11, 2);
      check("t5_frame", 32'(err_frame[0]), 1);
      check("t5_count", 32'(count[0]), 1);
      check("t5_data", 32'(rd_data[0]), 32'h7E);
      clear(0);
      check("t5_clr", 32'(err_frame[0]), 0);
      pop(0);

      // Odd parity: 0xA5 has four ones, so the correct parity bit is 1
      send(1, 8'hA5, 0, 2'b11, 1);
      check("t3_parity_err", 32'(err_parity[1]), 1);
      check("t3_dropped", 32'(count[1]), 0);
      send(1, 8'hA5, 1, 2'b11, 1);
      check("t3_data", 32'(rd_data[1]), 32'hA5);
      check("t3_count", 32'(count[1]), 1);
      clear(1);
      pop(1);

      // Start glitch of 2 clk at 8 clk/bit
      rx[1] = 1'b0;
      repeat (2) @(negedge clk);
      rx[1] = 1'b1;
      repeat (30) @(negedge clk);
      check("t4_count", 32'(count[1]), 0);
      check("t4_flags", 32'({err_frame[1], err_parity[1], err_overrun[1]}), 0);

      // Reset in the middle of the data bits
      rx[1] = 1'b0;
      repeat (8) @(negedge clk);
      rx[1] = 1'b1;
      repeat (16) @(negedge clk);
      rx[1] = 1'b0;
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      rx[1] = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      send(1, 8'h55, 1, 2'b11, 1);
      check("t6_count", 32'(count[1]), 1);
      check("t6_data", 32'(rd_data[1]), 32'h55);
      check("t6_flags", 32'({err_frame[1], err_parity[1], err_overrun[1]}), 0);
      pop(1);

      run_random(0, 40);
      run_random(1, 15);
      repeat (20) @(negedge clk);
      check("events_drained", 32'(evq.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
